fb_inst_enc: RTL and testbench
==============================

# fb_inst_enc

Instruction encoder: packs decoded RISC-V RV32I fields plus a full 32-bit immediate back into a 32-bit instruction word. It is the inverse of the immediate-generation path. It sits between the test/trace generator and instruction memory, and in the self-check loop that feeds encoded words back through the decoder. The block has a valid/ready input, a registered output with a skid buffer, and a saturating error counter.

## Interface
- `ERR_CNT_W`, default 8: width of the saturating error counter.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input fields valid.
- `in_ready` out 1: block can accept; registered.
- `in_fmt` in 3: format select. 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- `in_opcode` in 7: opcode bits [6:0].
- `in_rd`, `in_rs1`, `in_rs2` in 5 each: register indices.
- `in_funct3` in 3 / `in_funct7` in 7: function fields.
- `in_imm` in `FB_32BITS`: signed byte-offset immediate, or upper value for U.
- `out_valid` out 1: `out_inst` valid.
- `out_ready` in 1: consumer accepts.
- `out_inst` out `FB_32BITS`: encoded instruction.
- `out_err` out 1: encoding error for this word.
- `err_cnt` out `ERR_CNT_W`: count of errored words accepted at input; saturates at all-ones.

## Operation
- Input transfer occurs on `in_valid && in_ready`. Output transfer occurs on `out_valid && out_ready`.
- Field placement, bit [31] first:
  - R: {f7, rs2, rs1, f3, rd, opc}
  - I: {imm[11:0], rs1, f3, rd, opc}
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], opc}
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc}
  - U: {imm[31:12], rd, opc}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc}
- Fields not used by a format are ignored.
- Illegal `in_fmt` produces `out_inst`=0 and `out_err`=1. This happens regardless of configuration.
- `err_cnt` increments on each input transfer whose computed error is 1. It holds at its maximum value.
- Buffering: one main output register M and one skid register S.
  - `in_ready` = !S.valid.
  - On an input transfer: if M is empty, or M is transferring this cycle, the word loads M. Otherwise it loads S.
  - When M transfers and S is valid, S moves to M and S empties. The incoming word cannot go to S in this case, because `in_ready` was 0.
- Words leave in order. None are dropped or duplicated.

## Timing
- Latency is 1 cycle: a word accepted at edge N is on `out_inst`/`out_valid` after edge N.
- Throughput is 1 word per cycle while `out_ready`=1.
- `in_ready` falls the cycle after S fills. It rises the cycle after S drains.
- Reset values: `out_valid`=0, `out_inst`=0, `out_err`=0, `err_cnt`=0, `in_ready`=1. M and S are emptied.
- Reset mid-stream discards buffered words. An `in_valid` coinciding with `rst` is not accepted.
- `out_inst`/`out_err` stay stable while `out_valid && !out_ready`.

## Configuration
- `FB_ENC_RANGE_CHECK_EN` defined: the immediate range check is active, and `out_err`=1 when the immediate does not fit. `out_inst` still holds the truncated encoding. Violations per format:
  - I/S: `in_imm` is not the sign extension of imm[11:0].
  - B: imm[0]≠0, or `in_imm` is not the sign extension of imm[12:0].
  - J: imm[0]≠0, or `in_imm` is not the sign extension of imm[20:0].
  - U: imm[11:0]≠0.
- `FB_ENC_RANGE_CHECK_EN` undefined: no range check. Out-of-range bits are silently truncated, and `out_err` reflects illegal format only.

## Structure
- Add to `fb_defines.v`: format codes (`FB_FMT_R`..`FB_FMT_J`), `FB_32BITS` (already present), and field widths.
- Sub-module `fb_inst_pack`: purely combinational. It computes the word and error from the fields.
- `fb_inst_enc` holds the handshake, M/S buffering and `err_cnt`.

## Test plan
- I, opc 0x13, rd=1, rs1=0, f3=0, imm=5 → `out_inst`=0x00500093, `out_err`=0, one cycle after accept.
- S, opc 0x23, f3=2, rs1=1, rs2=2, imm=8 → 0x0020A423. B, opc 0x63, rs1=rs2=0, imm=-4 → 0xFE000EE3.
- J, opc 0x6F, rd=1, imm=0x800 → 0x001000EF. `in_fmt`=7 → `out_inst`=0, `out_err`=1, `err_cnt` increments by 1.
- I, imm=0x800 → `out_inst`=0x80000093. With the macro: `out_err`=1 and `err_cnt`+1. Without it: `out_err`=0.
- Hold `out_ready`=0 and stream 3 words → 2 accepted, `in_ready`=0 on the cycle after the 2nd. Release `out_ready` → the words emerge in order with no loss.
- Assert `rst` with M and S full → the next cycle has `out_valid`=0, `in_ready`=1, `err_cnt`=0. Saturation: 300 illegal words with `ERR_CNT_W`=8 → `err_cnt`=255.

Source files
------------

// File: rtl/fb_inst_enc_pkg.sv
// Shared constants for the RV32I instruction encoder: format codes, field widths
// and the immediate sign-extension helper used by the optional range check.
package fb_inst_enc_pkg;

  localparam int FB_32BITS = 32;
  localparam int FB_OPC_W  = 7;
  localparam int FB_REG_W  = 5;
  localparam int FB_F3_W   = 3;
  localparam int FB_F7_W   = 7;
  localparam int FB_FMT_W  = 3;

  typedef enum logic [FB_FMT_W-1:0] {
    FB_FMT_R = 3'd0,
    FB_FMT_I = 3'd1,
    FB_FMT_S = 3'd2,
    FB_FMT_B = 3'd3,
    FB_FMT_U = 3'd4,
    FB_FMT_J = 3'd5
  } fb_fmt_e;

  // True when bits [31:msb] of v are all equal, i.e. v is the sign extension of v[msb:0].
  function automatic logic fb_sext_ok(input logic [FB_32BITS-1:0] v, input int unsigned msb);
    logic [FB_32BITS-1:0] m;
    m = {FB_32BITS{1'b1}} << msb;
    return ((v & m) == m) || ((v & m) == '0);
  endfunction

endpackage

// File: rtl/fb_inst_pack.sv
// Combinational field packer: decoded fields + 32-bit immediate -> instruction word.
// Immediate range checking is compiled in only when FB_ENC_RANGE_CHECK_EN is defined.
module fb_inst_pack
  import fb_inst_enc_pkg::*;
(
  input  logic [FB_FMT_W-1:0]  i_fmt,
  input  logic [FB_OPC_W-1:0]  i_opcode,
  input  logic [FB_REG_W-1:0]  i_rd,
  input  logic [FB_REG_W-1:0]  i_rs1,
  input  logic [FB_REG_W-1:0]  i_rs2,
  input  logic [FB_F3_W-1:0]   i_funct3,
  input  logic [FB_F7_W-1:0]   i_funct7,
  input  logic [FB_32BITS-1:0] i_imm,
  output logic [FB_32BITS-1:0] o_inst,
  output logic                 o_err
);

  logic w_rng_err;

  always_comb begin
    o_inst    = '0;
    o_err     = 1'b0;
    w_rng_err = 1'b0;
    case (i_fmt)
      FB_FMT_R: o_inst = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      FB_FMT_I: begin
        o_inst    = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        w_rng_err = !fb_sext_ok(i_imm, 11);
      end
      FB_FMT_S: begin
        o_inst    = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        w_rng_err = !fb_sext_ok(i_imm, 11);
      end
      FB_FMT_B: begin
        o_inst    = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3, i_imm[4:1], i_imm[11], i_opcode};
        w_rng_err = i_imm[0] || !fb_sext_ok(i_imm, 12);
      end
      FB_FMT_U: begin
        o_inst    = {i_imm[31:12], i_rd, i_opcode};
        w_rng_err = |i_imm[11:0];
      end
      FB_FMT_J: begin
        o_inst    = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
        w_rng_err = i_imm[0] || !fb_sext_ok(i_imm, 20);
      end
      default: o_err = 1'b1;  // illegal format: word forced to zero
    endcase
`ifdef FB_ENC_RANGE_CHECK_EN
    o_err = o_err | w_rng_err;
`endif
  end

endmodule

// File: rtl/fb_inst_enc.sv
// Instruction encoder top: valid/ready input, main + skid output registers, and a
// saturating error counter. Optional immediate range check via FB_ENC_RANGE_CHECK_EN.
module fb_inst_enc
  import fb_inst_enc_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FB_FMT_W-1:0]  in_fmt,
  input  logic [FB_OPC_W-1:0]  in_opcode,
  input  logic [FB_REG_W-1:0]  in_rd,
  input  logic [FB_REG_W-1:0]  in_rs1,
  input  logic [FB_REG_W-1:0]  in_rs2,
  input  logic [FB_F3_W-1:0]   in_funct3,
  input  logic [FB_F7_W-1:0]   in_funct7,
  input  logic [FB_32BITS-1:0] in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FB_32BITS-1:0] out_inst,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [FB_32BITS-1:0] w_inst;
  logic                 w_err;
  logic                 w_in_xfer, w_out_xfer, w_s_vld_nxt;

  logic                 r_m_vld, r_m_err, r_s_vld, r_s_err, r_in_rdy;
  logic [FB_32BITS-1:0] r_m_inst, r_s_inst;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  fb_inst_pack u_pack (
    .i_fmt    (in_fmt),
    .i_opcode (in_opcode),
    .i_rd     (in_rd),
    .i_rs1    (in_rs1),
    .i_rs2    (in_rs2),
    .i_funct3 (in_funct3),
    .i_funct7 (in_funct7),
    .i_imm    (in_imm),
    .o_inst   (w_inst),
    .o_err    (w_err)
  );

  assign w_in_xfer  = in_valid && r_in_rdy;
  assign w_out_xfer = r_m_vld && out_ready;

  // S only fills when M is occupied and not draining; it drains whenever M transfers.
  always_comb begin
    w_s_vld_nxt = r_s_vld;
    if (w_out_xfer && r_s_vld)                       w_s_vld_nxt = 1'b0;
    else if (w_in_xfer && r_m_vld && !w_out_xfer)    w_s_vld_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_vld   <= 1'b0;
      r_m_inst  <= '0;
      r_m_err   <= 1'b0;
      r_s_vld   <= 1'b0;
      r_s_inst  <= '0;
      r_s_err   <= 1'b0;
      r_in_rdy  <= 1'b1;
      r_err_cnt <= '0;
    end else begin
      r_s_vld  <= w_s_vld_nxt;
      r_in_rdy <= !w_s_vld_nxt;
      if (w_out_xfer) begin
        if (r_s_vld) begin
          r_m_inst <= r_s_inst;
          r_m_err  <= r_s_err;
        end else begin
          r_m_vld  <= 1'b0;
        end
      end
      if (w_in_xfer) begin
        if (!r_m_vld || w_out_xfer) begin
          r_m_vld  <= 1'b1;
          r_m_inst <= w_inst;
          r_m_err  <= w_err;
        end else begin
          r_s_inst <= w_inst;
          r_s_err  <= w_err;
        end
        if (w_err && (r_err_cnt != {ERR_CNT_W{1'b1}}))
          r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign in_ready  = r_in_rdy;
  assign out_valid = r_m_vld;
  assign out_inst  = r_m_inst;
  assign out_err   = r_m_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_fb_inst_enc.sv
// Directed bench for fb_inst_enc: encoding vector table, skid backpressure,
// reset with full buffers, and error counter saturation.
module tb_fb_inst_enc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, out_inst;
  logic [7:0]  err_cnt;

  int n_chk = 0;
  int n_err = 0;
  int exp_cnt = 0;

`ifdef FB_ENC_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  fb_inst_enc #(.ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  fmt;
    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_inst;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive(input vec_t v);
    in_fmt = v.fmt; in_opcode = v.opc; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
  endtask

  function automatic vec_t addi(input logic [31:0] imm);
    vec_t v;
    v = '{"addi", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, imm, 32'h0, 1'b0};
    return v;
  endfunction

  initial begin
    vecs[0] = '{"I_addi5",  3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,        32'h00500093, 1'b0};
    vecs[1] = '{"S_sw8",    3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,        32'h0020A423, 1'b0};
    vecs[2] = '{"B_m4",     3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0};
    vecs[3] = '{"J_800",    3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800, 32'h001000EF, 1'b0};
    vecs[4] = '{"fmt7",     3'd7, 7'h13, 5'd1, 5'd2, 5'd3, 3'd1, 7'h7F, 32'h12345678, 32'h00000000, 1'b1};
    vecs[5] = '{"I_800",    3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800, 32'h80000093, RC};
    vecs[6] = '{"R_sub",    3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hDEADBEEF, 32'h403100B3, 1'b0};
    vecs[7] = '{"U_lui",    3'd4, 7'h37, 5'd5, 5'd9, 5'd9, 3'd7, 7'h7F, 32'h12345000, 32'h123452B7, 1'b0};
    vecs[8] = '{"U_low",    3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345678, 32'h123452B7, RC};
    vecs[9] = '{"fmt6",     3'd6, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0,        32'h00000000, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(vecs[0]);
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_inst",  out_inst, 32'd0);
    chk("rst_out_err",   {31'd0, out_err}, 32'd0);
    chk("rst_err_cnt",   {24'd0, err_cnt}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);

    // Vector table, one word per cycle, output always ready
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i]); in_valid = 1'b1;
      cyc();
      if (vecs[i].exp_err) exp_cnt++;
      chk({vecs[i].name, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({vecs[i].name, "_inst"},  out_inst, vecs[i].exp_inst);
      chk({vecs[i].name, "_err"},   {31'd0, out_err}, {31'd0, vecs[i].exp_err});
      chk({vecs[i].name, "_cnt"},   {24'd0, err_cnt}, exp_cnt);
    end
    in_valid = 1'b0;
    cyc();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: three words offered, two taken, then released in order
    out_ready = 1'b0;
    drive(addi(32'd1)); in_valid = 1'b1;
    cyc();
    chk("bp_m_inst", out_inst, 32'h00100093);
    chk("bp_rdy1",   {31'd0, in_ready}, 32'd1);
    drive(addi(32'd2));
    cyc();
    chk("bp_rdy2",   {31'd0, in_ready}, 32'd0);
    chk("bp_hold",   out_inst, 32'h00100093);
    drive(addi(32'd3));
    cyc();
    chk("bp_rdy3",   {31'd0, in_ready}, 32'd0);
    chk("bp_hold2",  out_inst, 32'h00100093);
    chk("bp_valid",  {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    cyc();
    chk("bp_w1",     out_inst, 32'h00200093);
    chk("bp_rdy_up", {31'd0, in_ready}, 32'd1);
    cyc();
    chk("bp_w2",     out_inst, 32'h00300093);
    chk("bp_w2_vld", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    cyc();
    chk("bp_empty",  {31'd0, out_valid}, 32'd0);

    // Reset with M and S full; an input coinciding with reset is not taken
    out_ready = 1'b0;
    drive(vecs[4]); in_valid = 1'b1;
    cyc(); cyc();
    exp_cnt += 2;
    chk("full_rdy",  {31'd0, in_ready}, 32'd0);
    chk("full_cnt",  {24'd0, err_cnt}, exp_cnt);
    out_ready = 1'b1;
    rst = 1'b1;
    cyc();
    rst = 1'b0; in_valid = 1'b0;
    exp_cnt = 0;
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_rdy",   {31'd0, in_ready}, 32'd1);
    chk("mrst_cnt",   {24'd0, err_cnt}, 32'd0);
    chk("mrst_inst",  out_inst, 32'd0);
    cyc();
    chk("mrst_nodup", {31'd0, out_valid}, 32'd0);

    // Saturation: 300 illegal words, streamed
    drive(vecs[4]); in_valid = 1'b1;
    for (int i = 0; i < 254; i++) cyc();
    chk("sat_254", {24'd0, err_cnt}, 32'd254);
    for (int i = 0; i < 46; i++) cyc();
    in_valid = 1'b0;
    chk("sat_255", {24'd0, err_cnt}, 32'd255);
    cyc();
    chk("sat_hold", {24'd0, err_cnt}, 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
